// File: rtl/column_spike_decoder.sv
// column_spike_decoder
// Samples a column's race-logic spike bus over one gamma window, converts each
// neuron's first rising edge into a binary spike time, picks the earliest
// firing neuron (lowest index on ties) and offers the result on valid/ready.

`ifndef NEURONS_PER_COLUMN
`define NEURONS_PER_COLUMN 4
`endif
`ifndef TIME_PERIOD
`define TIME_PERIOD 8
`endif

module column_spike_decoder #(
    parameter int NEURONS = `NEURONS_PER_COLUMN,
    parameter int PERIOD  = `TIME_PERIOD,
    parameter int TW      = $clog2(PERIOD + 1),
    parameter int IW      = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        gamma_start,
    input  logic [NEURONS-1:0]          in_spikes,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NEURONS-1:0][TW-1:0]  out_times,
    output logic [IW-1:0]               out_winner,
    output logic                        out_any
);

    // PERIOD doubles as the "never fired" time code.
    localparam logic [TW-1:0] NO_SPIKE = TW'(PERIOD);
    localparam logic [TW-1:0] LAST_T   = TW'(PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        RESOLVE,
        HOLD
    } state_t;

    state_t        state;
    logic [TW-1:0] t;
    logic [TW-1:0] min_val;
    logic [IW-1:0] min_idx;

    assign busy = (state != IDLE);

    // Winner-take-all search: strict less-than keeps the lowest index on ties,
    // and with no spikes the index stays at zero.
    always_comb begin
        min_val = NO_SPIKE;
        min_idx = '0;
        for (int i = 0; i < NEURONS; i++) begin
            if (out_times[i] < min_val) begin
                min_val = out_times[i];
                min_idx = IW'(i);
            end
        end
    end

    // Window sequencer: first-rise capture, one-cycle resolve, then hold the
    // result until accepted (optionally chaining straight into a new window).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            t          <= '0;
            out_valid  <= 1'b0;
            out_any    <= 1'b0;
            out_winner <= '0;
            out_times  <= {NEURONS{NO_SPIKE}};
        end else begin
            case (state)
                IDLE: begin
                    if (gamma_start) begin
                        state      <= CAPTURE;
                        t          <= '0;
                        out_any    <= 1'b0;
                        out_winner <= '0;
                        out_times  <= {NEURONS{NO_SPIKE}};
                    end
                end
                CAPTURE: begin
                    for (int i = 0; i < NEURONS; i++) begin
                        if ((out_times[i] == NO_SPIKE) && in_spikes[i]) begin
                            out_times[i] <= t;
                        end
                    end
                    if (t == LAST_T) begin
                        state <= RESOLVE;
                    end else begin
                        t <= t + TW'(1);
                    end
                end
                RESOLVE: begin
                    out_winner <= min_idx;
                    out_any    <= (min_val != NO_SPIKE);
                    out_valid  <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (gamma_start) begin
                            state      <= CAPTURE;
                            t          <= '0;
                            out_any    <= 1'b0;
                            out_winner <= '0;
                            out_times  <= {NEURONS{NO_SPIKE}};
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/column_spike_decoder.md
# column_spike_decoder

Receive-side decoder for an excitatory column's output spike bus. It samples the column's step-encoded (race-logic) output spikes over one gamma window of PERIOD clocks and converts each neuron's first rising time into a binary spike time. It then resolves the earliest-firing neuron (winner-take-all, lowest index on ties) and presents the result on a valid/ready handshake to the downstream learning/readout stage.

## Interface
- NEURONS, default `NEURONS_PER_COLUMN: width of the spike bus (number of column neurons)
- PERIOD, default `TIME_PERIOD: gamma window length in clocks; also the "no spike" time code
- TW, default $clog2(PERIOD+1): width of one spike-time field
- IW, default (NEURONS>1 ? $clog2(NEURONS) : 1): width of winner index

- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- gamma_start  input  1  one-cycle request to begin a capture window
- in_spikes  input  NEURONS  column output spikes; a bit rises once and stays high for the rest of the window
- busy  output  1  high in every state except IDLE
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_times  output  NEURONS x TW  per-neuron spike time, 0..PERIOD-1, or PERIOD = no spike
- out_winner  output  IW  index of earliest-firing neuron
- out_any  output  1  at least one neuron spiked in the window

## Operation
- Reset values: state IDLE, out_valid=0, busy=0, out_any=0, out_winner=0, every out_times field=PERIOD, time counter t=0.
- States: IDLE, CAPTURE, RESOLVE, HOLD.
- IDLE: gamma_start=1 -> CAPTURE. Clear all out_times to PERIOD, set t=0, out_any=0, out_winner=0.
- CAPTURE: each clock, for every i with out_times[i]==PERIOD and in_spikes[i]==1, set out_times[i]<=t. This is a first-rise capture; later samples never overwrite it. If t==PERIOD-1 -> RESOLVE, else t<=t+1.
- RESOLVE (one cycle): compute the minimum over out_times.
  - out_winner = lowest index holding that minimum.
  - out_any = (minimum != PERIOD).
  - If no neuron spiked: out_any=0 and out_winner=0.
  - Next state HOLD, with out_valid<=1.
- HOLD: outputs stay frozen.
  - out_valid && out_ready -> out_valid<=0 and IDLE.
  - If gamma_start=1 in the same cycle as the handshake, go directly to CAPTURE with the IDLE-entry clears instead.
- gamma_start is ignored in CAPTURE and RESOLVE, and in HOLD without out_ready; it is not queued.
- in_spikes is ignored outside CAPTURE. A bit already high at the first CAPTURE sample records time 0.
- Time arithmetic: t is TW bits and never exceeds PERIOD-1. The comparator tree compares TW-bit unsigned values.
- rst asserted at any point, including mid-CAPTURE or in HOLD, aborts to reset values. The partial window is discarded and no out_valid is produced.

## Timing
- Edge E0 samples gamma_start=1. Edges E1..E_PERIOD sample in_spikes for t=0..PERIOD-1. Edge E_PERIOD+1 performs RESOLVE. out_valid is high after E_PERIOD+1.
- Latency from gamma_start to out_valid is PERIOD+2 clocks.
- out_times is final after E_PERIOD. out_winner and out_any are valid with out_valid and held constant until the handshake edge.
- out_valid must not drop without out_ready.
- Minimum accepted-window throughput is one window per PERIOD+2 clocks, using the back-to-back handshake+gamma_start in HOLD.

## Test plan
- NEURONS=4, PERIOD=8: gamma_start, then bit2 rises at t=3, bit0 at t=5, others never. Required response after PERIOD+2 clocks:
  - out_times = {8,3,8,5} (index 3..0)
  - out_winner=2, out_any=1, out_valid=1
- Tie: bits 1 and 3 both rise at t=2 -> out_winner=1, out_times[1]=out_times[3]=2.
- No spikes in the window -> all out_times=8, out_any=0, out_winner=0, out_valid=1.
- Backpressure: hold out_ready=0 for 20 clocks, pulse gamma_start during HOLD -> outputs unchanged and the pulse ignored. Then out_ready=1 with gamma_start=1 in the same cycle -> next cycle busy=1 in CAPTURE, out_valid=0, times cleared to 8.
- Pre-high / glitch check: bit0 high before gamma_start -> time 0. A bit dropping and re-rising keeps its first time.
- Assert rst at t=4 of CAPTURE -> next cycle busy=0, out_valid=0, all out_times=8. A following normal window decodes correctly.
